// File: rtl/dcmac_seg_merge.sv
// Merges the four DCMAC receive segment FIFOs, read in strict rotating order,
// into one 128-bit AXI stream with byte-accurate tkeep, framing repair and statistics.
module dcmac_seg_merge #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,

  input  logic [127:0]         seg0_tdata,
  input  logic [3:0]           seg0_tid,
  input  logic [2:0]           seg0_tuser,
  input  logic                 seg0_tlast,
  input  logic                 seg0_tvalid,
  output logic                 seg0_tready,

  input  logic [127:0]         seg1_tdata,
  input  logic [3:0]           seg1_tid,
  input  logic [2:0]           seg1_tuser,
  input  logic                 seg1_tlast,
  input  logic                 seg1_tvalid,
  output logic                 seg1_tready,

  input  logic [127:0]         seg2_tdata,
  input  logic [3:0]           seg2_tid,
  input  logic [2:0]           seg2_tuser,
  input  logic                 seg2_tlast,
  input  logic                 seg2_tvalid,
  output logic                 seg2_tready,

  input  logic [127:0]         seg3_tdata,
  input  logic [3:0]           seg3_tid,
  input  logic [2:0]           seg3_tuser,
  input  logic                 seg3_tlast,
  input  logic                 seg3_tvalid,
  output logic                 seg3_tready,

  output logic [127:0]         m_axis_tdata,
  output logic [15:0]          m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,

  input  logic                 clear_counters,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  typedef enum logic [0:0] {HUNT, PKT} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q;
  logic [1:0]           ptr_q;
  logic                 term_pending_q;
  logic                 sticky_err_q;

  logic [127:0]         tdata_q;
  logic [15:0]          tkeep_q;
  logic                 tlast_q;
  logic                 tuser_q;
  logic                 tvalid_q;

  logic [CNT_WIDTH-1:0] pkt_cnt_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  logic [127:0]         seg_data  [4];
  logic [3:0]           seg_mty   [4];
  logic [2:0]           seg_flags [4];
  logic [3:0]           seg_last;
  logic [3:0]           seg_valid;

  assign seg_data[0]  = seg0_tdata;
  assign seg_data[1]  = seg1_tdata;
  assign seg_data[2]  = seg2_tdata;
  assign seg_data[3]  = seg3_tdata;
  assign seg_mty[0]   = seg0_tid;
  assign seg_mty[1]   = seg1_tid;
  assign seg_mty[2]   = seg2_tid;
  assign seg_mty[3]   = seg3_tid;
  assign seg_flags[0] = seg0_tuser;
  assign seg_flags[1] = seg1_tuser;
  assign seg_flags[2] = seg2_tuser;
  assign seg_flags[3] = seg3_tuser;
  assign seg_last     = {seg3_tlast, seg2_tlast, seg1_tlast, seg0_tlast};
  assign seg_valid    = {seg3_tvalid, seg2_tvalid, seg1_tvalid, seg0_tvalid};

  // Head of the FIFO currently selected by the rotating pointer.
  logic [127:0] h_data;
  logic [3:0]   h_mty;
  logic         h_ena, h_sop, h_err, h_last, h_valid, h_live;

  assign h_data  = seg_data[ptr_q];
  assign h_mty   = seg_mty[ptr_q];
  assign h_ena   = seg_flags[ptr_q][2];
  assign h_sop   = seg_flags[ptr_q][1];
  assign h_err   = seg_flags[ptr_q][0];
  assign h_last  = seg_last[ptr_q];
  assign h_valid = seg_valid[ptr_q];
  // Segments without ena are popped as idle slots and carry no framing.
  assign h_live  = h_valid && h_ena;

  logic       slot_free;
  logic       trunc_head;
  logic       rd_en;
  logic [3:0] rd_sel;
  logic       pop;
  logic       trunc_now;
  logic       term_req;
  logic       load_term;
  logic       fwd;
  logic       drop;
  logic       err_all;
  logic       inc_pkt;
  logic       inc_err;

  assign slot_free  = !tvalid_q || m_axis_tready;
  // A SOP at the head while a packet is open must stay in its FIFO until the terminator is out.
  assign trunc_head = (state_q == PKT) && h_sop && h_ena;
  assign rd_en      = resetn && slot_free && !term_pending_q && !trunc_head;
  assign rd_sel     = rd_en ? (4'b0001 << ptr_q) : 4'b0000;

  assign {seg3_tready, seg2_tready, seg1_tready, seg0_tready} = rd_sel;

  assign pop       = rd_en && h_valid;
  assign trunc_now = (state_q == PKT) && h_live && h_sop && !term_pending_q;
  assign term_req  = term_pending_q || trunc_now;
  assign load_term = term_req && slot_free;
  assign fwd       = pop && h_ena && ((state_q == PKT) || h_sop);
  assign drop      = pop && h_ena && (state_q == HUNT) && !h_sop;
  assign err_all   = sticky_err_q || h_err;
  assign inc_pkt   = fwd && h_last && !err_all;
  assign inc_err   = (fwd && h_last && err_all) || load_term;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= HUNT;
      ptr_q          <= 2'd0;
      term_pending_q <= 1'b0;
      sticky_err_q   <= 1'b0;
      tdata_q        <= '0;
      tkeep_q        <= '0;
      tlast_q        <= 1'b0;
      tuser_q        <= 1'b0;
      tvalid_q       <= 1'b0;
      pkt_cnt_q      <= '0;
      err_cnt_q      <= '0;
      drop_cnt_q     <= '0;
    end else begin
      if (pop) begin
        ptr_q <= ptr_q + 2'd1;
      end

      term_pending_q <= term_req && !slot_free;

      if (slot_free) begin
        if (fwd) begin
          tdata_q  <= h_data;
          tkeep_q  <= h_last ? (16'hFFFF >> h_mty) : 16'hFFFF;
          tlast_q  <= h_last;
          tuser_q  <= err_all;
          tvalid_q <= 1'b1;
        end else if (load_term) begin
          tdata_q  <= '0;
          tkeep_q  <= 16'h0000;
          tlast_q  <= 1'b1;
          tuser_q  <= 1'b1;
          tvalid_q <= 1'b1;
        end else begin
          tvalid_q <= 1'b0;
        end
      end

      if (load_term) begin
        state_q      <= HUNT;
        sticky_err_q <= 1'b0;
      end else if (fwd) begin
        state_q      <= h_last ? HUNT : PKT;
        sticky_err_q <= h_last ? 1'b0 : err_all;
      end

      if (clear_counters) begin
        pkt_cnt_q  <= '0;
        err_cnt_q  <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (inc_pkt) pkt_cnt_q  <= pkt_cnt_q + CNT_ONE;
        if (inc_err) err_cnt_q  <= err_cnt_q + CNT_ONE;
        if (drop)    drop_cnt_q <= drop_cnt_q + CNT_ONE;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;

  assign pkt_count  = pkt_cnt_q;
  assign err_count  = err_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_dcmac_seg_merge.sv
// Randomized bench for dcmac_seg_merge: per-segment FIFO models feed the DUT and a
// packet-level reference model predicts every output beat and counter.
module tb_dcmac_seg_merge;

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   mty;
    logic         sop;
    logic         err;
    logic         last;
  } seg_t;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [127:0] s_tdata  [4];
  logic [3:0]   s_tid    [4];
  logic [2:0]   s_tuser  [4];
  logic         s_tlast  [4];
  logic         s_tvalid [4];
  logic         s_tready [4];
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast, m_tuser, m_tvalid, m_tready;
  logic         clr;
  logic [31:0]  pkt_count, err_count, drop_count;

  dcmac_seg_merge #(.CNT_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .seg0_tdata(s_tdata[0]), .seg0_tid(s_tid[0]), .seg0_tuser(s_tuser[0]),
    .seg0_tlast(s_tlast[0]), .seg0_tvalid(s_tvalid[0]), .seg0_tready(s_tready[0]),
    .seg1_tdata(s_tdata[1]), .seg1_tid(s_tid[1]), .seg1_tuser(s_tuser[1]),
    .seg1_tlast(s_tlast[1]), .seg1_tvalid(s_tvalid[1]), .seg1_tready(s_tready[1]),
    .seg2_tdata(s_tdata[2]), .seg2_tid(s_tid[2]), .seg2_tuser(s_tuser[2]),
    .seg2_tlast(s_tlast[2]), .seg2_tvalid(s_tvalid[2]), .seg2_tready(s_tready[2]),
    .seg3_tdata(s_tdata[3]), .seg3_tid(s_tid[3]), .seg3_tuser(s_tuser[3]),
    .seg3_tlast(s_tlast[3]), .seg3_tvalid(s_tvalid[3]), .seg3_tready(s_tready[3]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .clear_counters(clr),
    .pkt_count(pkt_count), .err_count(err_count), .drop_count(drop_count)
  );

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  seg_t  fq [4][$];
  seg_t  list[$];
  beat_t exp_q[$];

  bit          m_inpkt, m_sticky, ign_inc;
  logic [31:0] m_pkt, m_err, m_drop;
  int          exp_ptr;

  bit           prev_stall;
  logic [146:0] prev_out;
  bit           pops [4];

  task automatic model_reset();
    m_inpkt = 0; m_sticky = 0; ign_inc = 0;
    m_pkt = 0; m_err = 0; m_drop = 0;
    exp_ptr = 0;
  endtask

  // Packet-level rules: an open packet hit by a new SOP is closed by an empty error beat,
  // non-SOP data outside a packet is discarded, everything else is forwarded.
  task automatic model_seg(input seg_t s);
    bit    e;
    beat_t b;
    if (m_inpkt && s.sop) begin
      b = '{d: 128'h0, k: 16'h0000, l: 1'b1, u: 1'b1};
      exp_q.push_back(b);
      if (ign_inc) ign_inc = 0; else m_err++;
      m_inpkt = 0;
      m_sticky = 0;
    end
    if (!m_inpkt && !s.sop) begin
      if (ign_inc) ign_inc = 0; else m_drop++;
      return;
    end
    e = m_sticky | s.err;
    b.d = s.d;
    b.l = s.last;
    b.k = s.last ? (16'hFFFF >> s.mty) : 16'hFFFF;
    b.u = s.last & e;
    exp_q.push_back(b);
    if (s.last) begin
      if (ign_inc) ign_inc = 0;
      else if (e) m_err++;
      else m_pkt++;
      m_inpkt = 0;
      m_sticky = 0;
    end else begin
      m_inpkt = 1;
      m_sticky = e;
    end
  endtask

  task automatic add(input logic [3:0] mty, input bit sop, input bit err, input bit last);
    seg_t s;
    s.d = {$urandom, $urandom, $urandom, $urandom};
    s.mty = mty; s.sop = sop; s.err = err; s.last = last;
    list.push_back(s);
  endtask

  task automatic drive_segs(input bit gap);
    for (int n = 0; n < 4; n++) begin
      if (fq[n].size() > 0) begin
        s_tdata[n]  = fq[n][0].d;
        s_tid[n]    = fq[n][0].mty;
        s_tuser[n]  = {1'b1, fq[n][0].sop, fq[n][0].err};
        s_tlast[n]  = fq[n][0].last;
        s_tvalid[n] = !(gap && ($urandom_range(0, 3) == 0));
      end else begin
        s_tdata[n]  = '0;
        s_tid[n]    = '0;
        s_tuser[n]  = '0;
        s_tlast[n]  = 1'b0;
        s_tvalid[n] = 1'b0;
      end
    end
  endtask

  task automatic apply_pops();
    for (int n = 0; n < 4; n++)
      if (pops[n]) void'(fq[n].pop_front());
  endtask

  task automatic observe();
    beat_t b;
    if (prev_stall)
      check("stable", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, prev_out);
    if (m_tvalid && !m_tready)
      check("rdy_stall", {s_tready[3], s_tready[2], s_tready[1], s_tready[0]}, 0);
    prev_stall = m_tvalid && !m_tready;
    prev_out   = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser};
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        b = exp_q.pop_front();
        check("beat", {m_tdata, m_tkeep, m_tlast, m_tuser & m_tlast}, {b.d, b.k, b.l, b.u});
      end
    end
    for (int n = 0; n < 4; n++) pops[n] = s_tvalid[n] && s_tready[n];
  endtask

  // ready_mode: 0 = always ready, 1 = pattern 1,0,0,..., 2 = random.
  task automatic run(input int ready_mode, input bit gap, input bit clr_first);
    int cyc;
    int max_cyc;
    if (clr_first) begin
      m_pkt = 0; m_err = 0; m_drop = 0; ign_inc = 1;
    end
    for (int k = 0; k < list.size(); k++) begin
      fq[(exp_ptr + k) % 4].push_back(list[k]);
      model_seg(list[k]);
    end
    exp_ptr = (exp_ptr + list.size()) % 4;
    max_cyc = 20 * list.size() + 50;
    list.delete();
    cyc = 0;
    forever begin
      drive_segs(gap);
      clr = clr_first && (cyc == 0);
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 3 == 0);
        default: m_tready = $urandom_range(0, 1);
      endcase
      @(negedge clk);
      observe();
      if (fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 &&
          fq[3].size() == 0 && exp_q.size() == 0 && !m_tvalid) break;
      if (cyc >= max_cyc) begin
        check("timeout", 1, 0);
        break;
      end
      @(posedge clk);
      #1;
      apply_pops();
      cyc++;
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int n = 0; n < 4; n++) fq[n].delete();
    exp_q.delete();
    check("pkt_count", pkt_count, m_pkt);
    check("err_count", err_count, m_err);
    check("drop_count", drop_count, m_drop);
    check("ptr", dut.ptr_q, exp_ptr);
  endtask

  initial begin
    model_reset();
    prev_stall = 0;
    resetn = 1'b0;
    clr = 1'b0;
    m_tready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      s_tdata[n] = '1; s_tid[n] = '0; s_tuser[n] = 3'b110; s_tlast[n] = 1'b1; s_tvalid[n] = 1'b1;
    end
    #22;
    check("rst_out", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
    check("rst_ready", {s_tready[3], s_tready[2], s_tready[1], s_tready[0]}, 0);
    check("rst_cnt", {pkt_count, err_count, drop_count}, 0);
    for (int n = 0; n < 4; n++) s_tvalid[n] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Rotating order: one packet over seg0..seg3, last beat keeps 4 bytes.
    add(4'd0, 1, 0, 0); add(4'd0, 0, 0, 0); add(4'd0, 0, 0, 0); add(4'd12, 0, 0, 1);
    run(0, 0, 0);
    // Same stream under backpressure.
    add(4'd0, 1, 0, 0); add(4'd0, 0, 0, 0); add(4'd0, 0, 0, 0); add(4'd12, 0, 0, 1);
    run(1, 0, 0);
    // Hunt discard.
    add(4'd3, 0, 0, 0); add(4'd7, 0, 0, 1); add(4'd0, 1, 0, 1);
    run(0, 0, 0);
    // Truncation.
    add(4'd0, 1, 0, 0); add(4'd0, 0, 0, 0); add(4'd9, 1, 0, 1);
    run(0, 0, 0);
    // Truncation while stalled.
    add(4'd0, 1, 0, 0); add(4'd0, 0, 0, 0); add(4'd9, 1, 0, 1);
    run(1, 0, 0);
    // Error in the middle segment.
    add(4'd0, 1, 0, 0); add(4'd0, 0, 1, 0); add(4'd5, 0, 0, 1);
    run(0, 0, 0);
    // Clear coincides with a packet increment.
    add(4'd15, 1, 0, 1);
    run(0, 0, 1);
    // Randomized traffic.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 60; i++)
        add(4'($urandom_range(0, 15)), $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 3);
      run(2, 1, 0);
    end

    // Asynchronous reset with a beat stalled in the output register.
    add(4'd0, 1, 0, 0); add(4'd0, 0, 0, 0);
    for (int k = 0; k < list.size(); k++) fq[(exp_ptr + k) % 4].push_back(list[k]);
    list.delete();
    m_tready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive_segs(0);
      @(negedge clk);
      for (int n = 0; n < 4; n++) pops[n] = s_tvalid[n] && s_tready[n];
      @(posedge clk);
      #1;
      apply_pops();
    end
    check("stalled_before_rst", m_tvalid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_tvalid", m_tvalid, 0);
    check("async_rst_ready", {s_tready[3], s_tready[2], s_tready[1], s_tready[0]}, 0);
    for (int n = 0; n < 4; n++) fq[n].delete();
    model_reset();
    prev_stall = 0;
    drive_segs(0);
    m_tready = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("ptr_after_rst", dut.ptr_q, 0);
    // A leading non-SOP must be dropped, proving the block restarted hunting.
    add(4'd0, 0, 0, 0); add(4'd0, 1, 0, 1);
    run(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
